// File: rtl/ram_burst_if.sv
// Burst command, write-beat and read-beat handshakes between a requester and ram_burst_ctrl.
interface ram_burst_if #(
  parameter int ADDRESS_SIZE = 20,
  parameter int DATA_WIDTH   = 32,
  parameter int BURST_BITS   = 4
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDRESS_SIZE-1:0] cmd_addr;
  logic [BURST_BITS-1:0]   cmd_len;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    rd_valid;
  logic                    rd_ready;
  logic [DATA_WIDTH-1:0]   rd_data;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/ram_burst_ctrl.sv
// Burst read/write sequencer in front of a single-port asynchronous RAM.
// Define RAM_BOUNDARY_CHECK_EN to reject bursts that would run past the top of the address space.
//
// state | meaning
// IDLE  | waiting for a command (cmd_ready=1)
// WRITE | one RAM write per accepted wr beat
// READ  | loading RAM words into the registered read slot
// DONE  | one-cycle completion pulse
module ram_burst_ctrl #(
  parameter int ADDRESS_SIZE = 20,
  parameter int DATA_WIDTH   = 32,
  parameter int BURST_BITS   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  ram_burst_if.slave              bus,
  output logic                    done,
  output logic                    cmd_err,
  output logic                    busy,
  output logic [ADDRESS_SIZE-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  output logic                    ram_rdwr,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} stateType;

  stateType                state;
  stateType                nextState;
  logic [ADDRESS_SIZE-1:0] addr;
  logic [BURST_BITS-1:0]   beatsLeft;
  logic                    rdValid;
  logic [DATA_WIDTH-1:0]   rdData;
  logic                    accept;
  logic                    wrFire;
  logic                    rdLoad;
  logic                    lastBeat;
  logic                    rangeErr;

  always_comb begin
    accept   = bus.cmd_valid & (state == IDLE);
    wrFire   = (state == WRITE) & bus.wr_valid;
    rdLoad   = (state == READ) & (~rdValid | bus.rd_ready);
    lastBeat = (beatsLeft == '0);
`ifdef RAM_BOUNDARY_CHECK_EN
    // carry out of the end-address sum means the burst runs off the top
    rangeErr = ({1'b0, bus.cmd_addr} + (ADDRESS_SIZE + 1)'(bus.cmd_len))
               > {1'b0, {ADDRESS_SIZE{1'b1}}};
`else
    rangeErr = 1'b0;
`endif
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept && !rangeErr) nextState = bus.cmd_write ? WRITE : READ;
      WRITE:   if (wrFire && lastBeat) nextState = DONE;
      READ:    if (rdLoad && lastBeat) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      addr      <= '0;
      beatsLeft <= '0;
      rdValid   <= 1'b0;
      rdData    <= '0;
    end else begin
      state <= nextState;
      if (accept && !rangeErr) begin
        addr      <= bus.cmd_addr;
        beatsLeft <= bus.cmd_len;
      end else if (wrFire || rdLoad) begin
        addr      <= addr + ADDRESS_SIZE'(1);
        beatsLeft <= beatsLeft - BURST_BITS'(1);
      end
      if (rdLoad) begin
        rdData  <= ram_rdata;
        rdValid <= 1'b1;
      end else if (bus.rd_ready) begin
        rdValid <= 1'b0;
      end
    end
  end

`ifdef RAM_BOUNDARY_CHECK_EN
  logic cmdErrQ;
  always_ff @(posedge clk) begin
    if (!rst) cmdErrQ <= 1'b0;
    else      cmdErrQ <= accept & rangeErr;
  end
  assign cmd_err = cmdErrQ;
`else
  assign cmd_err = 1'b0;
`endif

  assign bus.cmd_ready = (state == IDLE);
  assign bus.wr_ready  = (state == WRITE);
  assign bus.rd_valid  = rdValid;
  assign bus.rd_data   = rdData;
  assign done          = (state == DONE);
  assign busy          = (state != IDLE);
  assign ram_addr      = addr;
  assign ram_wdata     = bus.wr_data;
  // a reset edge must never look like a write to the RAM
  assign ram_rdwr      = ~(rst & wrFire);

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Randomized bench for ram_burst_ctrl against a word-array memory reference model.
module tb_ram_burst_ctrl;
  localparam int AS = 20;
  localparam int DW = 32;
  localparam int BB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          done, cmd_err, busy, ram_rdwr;
  logic [AS-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  ram_burst_if #(.ADDRESS_SIZE(AS), .DATA_WIDTH(DW), .BURST_BITS(BB)) bus();

  ram_burst_ctrl #(.ADDRESS_SIZE(AS), .DATA_WIDTH(DW), .BURST_BITS(BB)) dut (
    .clk(clk), .rst(rst), .bus(bus), .done(done), .cmd_err(cmd_err), .busy(busy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdwr(ram_rdwr), .ram_rdata(ram_rdata)
  );

  // asynchronous RAM: combinational read, write on the clock edge while RDwr=0
  logic [DW-1:0] ramArr [4096];
  assign ram_rdata = ramArr[ram_addr[11:0]];
  always @(posedge clk) if (!ram_rdwr) ramArr[ram_addr[11:0]] <= ram_wdata;

  logic [DW-1:0] refMem [4096];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doWrite(input logic [AS-1:0] base, input int len, input bit gaps,
                         input bit randData, input logic [DW-1:0] d0);
    logic [AS-1:0] a;
    logic [DW-1:0] d;
    #1;
    chk("wr cmd_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_addr = base; bus.cmd_len = BB'(len);
    tick;
    bus.cmd_valid = 0; bus.cmd_addr = AS'($urandom);
    for (int k = 0; k <= len; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.wr_valid = 0; #1;
        chk("wr idle rdwr", ram_rdwr, 1);
        tick;
      end
      a = base + AS'(k);
      d = randData ? $urandom : d0 + DW'(k);
      bus.wr_valid = 1; bus.wr_data = d; #1;
      chk("wr ready", bus.wr_ready, 1);
      chk("wr rdwr", ram_rdwr, 0);
      chk("wr addr", ram_addr, a);
      chk("wr data", ram_wdata, d);
      chk("wr no done", done, 0);
      chk("wr cmd_ready low", bus.cmd_ready, 0);
      refMem[a[11:0]] = d;
      tick;
    end
    bus.wr_valid = 0; #1;
    chk("wr done", done, 1);
    chk("wr done rdwr", ram_rdwr, 1);
    tick;
    chk("wr done once", done, 0);
    chk("wr idle busy", busy, 0);
  endtask

  // mode 0: rd_ready high, 1: random rd_ready, 2: three stall cycles after the first beat
  task automatic doRead(input logic [AS-1:0] base, input int len, input int mode);
    logic [DW-1:0] expQ[$];
    logic [AS-1:0] a;
    int got, dones, stall, budget;
    for (int k = 0; k <= len; k++) begin
      a = base + AS'(k);
      expQ.push_back(refMem[a[11:0]]);
    end
    got = 0; dones = 0; stall = 0; budget = 0;
    #1;
    chk("rd cmd_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1; bus.cmd_write = 0; bus.cmd_addr = base; bus.cmd_len = BB'(len);
    bus.rd_ready = 1;
    tick;
    bus.cmd_valid = 0;
    chk("rd valid at E0", bus.rd_valid, 0);
    while (got <= len && budget < 300) begin
      case (mode)
        0: bus.rd_ready = 1;
        1: bus.rd_ready = 1'($urandom_range(0, 1));
        default: begin
          if (bus.rd_valid && stall < 3) begin
            bus.rd_ready = 0;
            stall++;
            chk("rd stall data", bus.rd_data, expQ[0]);
            chk("rd stall addr", ram_addr, base + AS'(1));
          end else begin
            bus.rd_ready = 1;
          end
        end
      endcase
      #1;
      if (mode == 0 && budget == 1) chk("rd valid after E1", bus.rd_valid, 1);
      if (done) dones++;
      if (bus.rd_valid && bus.rd_ready) begin
        chk("rd data", bus.rd_data, expQ[got]);
        got++;
      end
      tick;
      budget++;
    end
    chk("rd beat count", got, len + 1);
    if (mode == 0) chk("rd throughput", budget, len + 2);
    bus.rd_ready = 1;
    repeat (2) begin
      #1;
      if (done) dones++;
      tick;
    end
    chk("rd done pulses", dones, 1);
    chk("rd drained", bus.rd_valid, 0);
    chk("rd idle busy", busy, 0);
  endtask

  task automatic resetMidWrite;
    logic [AS-1:0] base;
    logic [DW-1:0] old;
    logic [AS-1:0] a;
    base = 20'h00200;
    a = base + AS'(3);
    old = ramArr[a[11:0]];
    bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_addr = base; bus.cmd_len = 4'd7;
    tick;
    bus.cmd_valid = 0;
    for (int k = 0; k < 3; k++) begin
      a = base + AS'(k);
      bus.wr_valid = 1; bus.wr_data = 32'hC000 + DW'(k);
      refMem[a[11:0]] = 32'hC000 + DW'(k);
      tick;
    end
    bus.wr_data = 32'hDEAD; rst = 0; #1;
    chk("rst rdwr forced", ram_rdwr, 1);
    chk("rst no done", done, 0);
    tick;
    a = base + AS'(3);
    chk("rst cmd_ready", bus.cmd_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst ram_addr", ram_addr, 0);
    chk("rst no write", ramArr[a[11:0]], old);
    rst = 1; #1;
    chk("idle ignores wr_valid", ram_rdwr, 1);
    tick;
    bus.wr_valid = 0;
    chk("rst no done after", done, 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ramArr[i] = '0;
      refMem[i] = '0;
    end
    rst = 0;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 0; bus.wr_data = 32'h1234_5678; bus.rd_ready = 0;
    tick; tick;
    chk("reset cmd_ready", bus.cmd_ready, 1);
    chk("reset wr_ready", bus.wr_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset cmd_err", cmd_err, 0);
    chk("reset rd_valid", bus.rd_valid, 0);
    chk("reset rd_data", bus.rd_data, 0);
    chk("reset rdwr", ram_rdwr, 1);
    chk("reset ram_addr", ram_addr, 0);
    chk("reset wdata", ram_wdata, 32'h1234_5678);
    rst = 1;
    tick;

    doWrite(20'h00010, 3, 0, 0, 32'hA0);
    doRead(20'h00010, 3, 0);
    doRead(20'h00010, 3, 2);
    resetMidWrite();
    doRead(20'h00200, 7, 0);

`ifdef RAM_BOUNDARY_CHECK_EN
    chk("oob cmd_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_addr = 20'hFFFFF; bus.cmd_len = 4'd1;
    bus.wr_valid = 1; bus.wr_data = 32'hBAD;
    tick;
    bus.cmd_valid = 0; #1;
    chk("oob cmd_err", cmd_err, 1);
    chk("oob busy", busy, 0);
    chk("oob rdwr", ram_rdwr, 1);
    chk("oob done", done, 0);
    tick;
    chk("oob cmd_err once", cmd_err, 0);
    chk("oob rdwr later", ram_rdwr, 1);
    chk("oob done later", done, 0);
    bus.wr_valid = 0;
    tick;
`else
    doWrite(20'hFFFFF, 1, 0, 0, 32'h5500);
    doRead(20'hFFFFF, 1, 0);
`endif

    repeat (8) begin
      logic [AS-1:0] b;
      b = AS'($urandom_range(0, 4000));
      doWrite(b, $urandom_range(0, 15), 1, 1, 0);
      doRead(AS'($urandom_range(0, 4000)), $urandom_range(0, 15), 1);
      doRead(b, $urandom_range(0, 15), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
